// File: rtl/fetch_unit.sv
// Instruction-fetch front end. Drives the word address into a synchronous-read
// instruction memory, hides its one-cycle read latency, and presents a
// valid/stall handshake plus a delivered-instruction count to decode.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | fetch parked, memory addressed at RESET_PC, nothing valid
// RUN   | one word in flight each cycle; resp_pc tags the returned word
module fetch_unit #(
    parameter int PC_WIDTH    = 10,
    parameter int INSTR_WIDTH = 32,
    parameter int RESET_PC    = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   run,
    input  logic                   stall,
    input  logic                   redirect_valid,
    input  logic [PC_WIDTH-1:0]    redirect_pc,
    output logic [PC_WIDTH-1:0]    imem_pc,
    input  logic [INSTR_WIDTH-1:0] imem_instruction,
    output logic                   if_valid,
    output logic [INSTR_WIDTH-1:0] if_instruction,
    output logic [PC_WIDTH-1:0]    if_pc,
    output logic [31:0]            if_count
);

    localparam logic [PC_WIDTH-1:0] RST_PC = PC_WIDTH'(RESET_PC);
    localparam logic [PC_WIDTH-1:0] PC_ONE = PC_WIDTH'(1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t              state, state_nx;
    logic [PC_WIDTH-1:0] fetch_pc, fetch_nx;
    logic [PC_WIDTH-1:0] resp_pc, resp_nx;
    logic [31:0]         count, count_nx;

    // State and PC/count registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            fetch_pc <= RST_PC;
            resp_pc  <= RST_PC;
            count    <= 32'd0;
        end else begin
            state    <= state_nx;
            fetch_pc <= fetch_nx;
            resp_pc  <= resp_nx;
            count    <= count_nx;
        end
    end

    // Next-state, next-PC and memory address selection
    always_comb begin
        state_nx = state;
        fetch_nx = fetch_pc;
        resp_nx  = resp_pc;
        imem_pc  = RST_PC;
        if_valid = 1'b0;
        count_nx = count;

        if (state == RUN) begin
            if_valid = !redirect_valid;
            // Any instruction decode actually takes is counted, including
            // the last one seen as run drops.
            if (if_valid && !stall)
                count_nx = count + 32'd1;

            if (redirect_valid)
                imem_pc = redirect_pc;
            else if (stall)
                imem_pc = resp_pc;      // re-read keeps the data stable
            else
                imem_pc = fetch_pc;

            if (!run) begin
                state_nx = IDLE;
                fetch_nx = RST_PC;
                resp_nx  = RST_PC;
            end else if (redirect_valid) begin
                resp_nx  = redirect_pc;
                fetch_nx = redirect_pc + PC_ONE;
            end else if (!stall) begin
                resp_nx  = fetch_pc;
                fetch_nx = fetch_pc + PC_ONE;
            end
        end else if (run) begin
            // RESET_PC is already being read while idle, so it lands next cycle.
            state_nx = RUN;
            resp_nx  = RST_PC;
            fetch_nx = RST_PC + PC_ONE;
        end
    end

    assign if_pc          = resp_pc;
    assign if_instruction = imem_instruction;
    assign if_count       = count;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch front end that drives the word address into the synchronous-read instruction memory and consumes the returned instruction word.
- Absorbs the memory's 1-cycle read latency.
- Presents a valid/stall handshake to the decode stage.
- Accepts PC redirects for branches and jumps.
- Keeps a count of delivered instructions.
- Sits between instructionmemory and the decode/register-read stage of the single-cycle/pipelined core.

Parameters:
PC_WIDTH, 10, width of the word address into instruction memory (1024 words)
INSTR_WIDTH, 32, instruction word width
RESET_PC, 0, first word address fetched after run is asserted

Ports:
clk  input  1  system clock; all state updates on posedge
rst_n  input  1  asynchronous active-low reset
run  input  1  1 = fetch enabled; 0 = park in IDLE (e.g. while memory is being loaded)
stall  input  1  decode stage cannot accept this cycle; hold the current instruction
redirect_valid  input  1  take redirect_pc as the next fetch address; squash the current output
redirect_pc  input  PC_WIDTH  redirect target (word address)
imem_pc  output  PC_WIDTH  word address to instruction memory; sampled by memory at posedge
imem_instruction  input  INSTR_WIDTH  memory data; the word addressed by imem_pc at the previous posedge
if_valid  output  1  if_instruction/if_pc hold a valid fetched instruction
if_instruction  output  INSTR_WIDTH  fetched instruction (pass-through of imem_instruction)
if_pc  output  PC_WIDTH  word address of if_instruction
if_count  output  32  number of instructions accepted by decode (if_valid && !stall)

Behaviour:
- Reset is asynchronous and active-low on rst_n; one clock, clk.
- Registers:
  - state ∈ {IDLE, RUN}
  - fetch_pc: next address to request
  - resp_pc: address of the word currently on imem_instruction
  - count: 32-bit delivered-instruction counter
- Values while rst_n=0:
  - state=IDLE, fetch_pc=RESET_PC, resp_pc=RESET_PC, count=0.
  - imem_pc=RESET_PC, if_valid=0, if_pc=RESET_PC, if_count=0.
  - if_instruction mirrors memory and is don't-care while if_valid=0.
- imem_pc (combinational), in priority order:
  - IDLE → RESET_PC
  - RUN && redirect_valid → redirect_pc
  - RUN && stall → resp_pc (re-reads the same word, so the output stays stable)
  - RUN otherwise → fetch_pc
- Outputs:
  - if_valid = (state==RUN) && !redirect_valid
  - if_pc = resp_pc
  - if_instruction = imem_instruction
  - if_count = count
- IDLE:
  - run=0 → stay.
  - run=1 → state<=RUN, resp_pc<=RESET_PC, fetch_pc<=RESET_PC+1.
  - Latency: first valid instruction (RESET_PC) appears the cycle after run is first sampled high.
- RUN, evaluated in priority order:
  1. run=0 → state<=IDLE, fetch_pc<=RESET_PC, resp_pc<=RESET_PC. The current-cycle output is still valid and counts if !stall.
  2. redirect_valid → resp_pc<=redirect_pc, fetch_pc<=redirect_pc+1. The current output is squashed and not counted. Redirect beats stall. Target is valid next cycle (one bubble cycle).
  3. stall → fetch_pc and resp_pc hold; count holds; if_valid stays 1 and if_instruction/if_pc stay constant for the whole stall.
  4. else → resp_pc<=fetch_pc, fetch_pc<=fetch_pc+1, count<=count+1. Steady state delivers one instruction per cycle.
- Arithmetic:
  - PC increment is modulo 2^PC_WIDTH: 1023+1 → 0, no error flag.
  - count wraps 2^32-1 → 0.
  - Addresses are word indices, not byte addresses.
- Reset mid-operation: outputs return to reset values immediately (asynchronously); any in-flight memory read is discarded.
- Back-to-back redirects: each redirect squashes the current cycle; only the last target is delivered.

Test Plan:
- Reset then run=1 for 4 cycles, program with mem[0]=0x00100513 and mem[1]=0x00150593 → cycle after run: if_valid=1, if_pc=0, if_instruction=0x00100513; next cycle if_pc=1, if_instruction=0x00150593; if_count=3 after 4 run cycles.
- stall held 3 cycles while if_pc=2 → if_pc=2 and if_instruction constant for all 3 cycles, imem_pc=2, if_count unchanged; release → if_pc=3 next cycle.
- redirect_valid=1, redirect_pc=20 while if_pc=5 → that cycle if_valid=0, imem_pc=20, count not incremented; next cycle if_pc=20, if_instruction=mem[20]; then if_pc=21.
- redirect and stall asserted together (redirect_pc=7) → redirect wins: next cycle if_pc=7, if_valid=1.
- redirect_pc=1023, no stall → if_pc sequence 1023, 0, 1.
- rst_n pulsed low mid-run with if_count=10 → immediately if_valid=0, imem_pc=0, if_count=0; after release with run=1, restarts at if_pc=0.
